// File: rtl/ecdsa_pkg.sv
// Shared constants and types for the sequential 64x64 limb multiplier.
// Operands are split into four 16-bit limbs; one limb product is accumulated per cycle.
package ecdsa_pkg;

    localparam int LIMB_W  = 16;
    localparam int N_LIMBS = 4;
    localparam int STEP_W  = 4;
    localparam int IDX_W   = 2;
    localparam int OP_W    = LIMB_W * N_LIMBS;
    localparam int PP_W    = 2 * LIMB_W;
    localparam int PROD_W  = 2 * OP_W;
    localparam int SHIFT_W = 7;

    localparam logic [STEP_W-1:0] LAST_STEP = '1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Bit offset of partial product a_i*b_j inside the 128-bit accumulator: 16*(i+j).
    function automatic logic [SHIFT_W-1:0] limb_shift(input logic [IDX_W-1:0] i,
                                                      input logic [IDX_W-1:0] j);
        logic [IDX_W:0] s;
        s = {1'b0, i} + {1'b0, j};
        return {s, 4'b0000};
    endfunction

endpackage

// File: rtl/limb_mul_16x16.sv
// Combinational unsigned 16x16 -> 32 limb multiplier.
module limb_mul_16x16
    import ecdsa_pkg::*;
(
    input  logic [LIMB_W-1:0] x,
    input  logic [LIMB_W-1:0] y,
    output logic [PP_W-1:0]   p
);

    assign p = {{LIMB_W{1'b0}}, x} * {{LIMB_W{1'b0}}, y};

endmodule

// File: rtl/mul_64x64_seq.sv
// Sequential unsigned 64x64 -> 128 multiplier: one 16x16 limb product per clock,
// 16 steps per operation, registered busy/done/out.
module mul_64x64_seq
    import ecdsa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic [PROD_W-1:0] out,
    output logic              done
);

    state_t              state_reg, state_next;
    logic [STEP_W-1:0]   k_reg, k_next;
    logic [OP_W-1:0]     a_reg, a_next;
    logic [OP_W-1:0]     b_reg, b_next;
    logic [PROD_W-1:0]   acc_reg, acc_next;
    logic [PROD_W-1:0]   out_reg, out_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    logic [LIMB_W-1:0]   a_limb [N_LIMBS];
    logic [LIMB_W-1:0]   b_limb [N_LIMBS];
    logic [IDX_W-1:0]    i_idx, j_idx;
    logic [LIMB_W-1:0]   a_sel, b_sel;
    logic [PP_W-1:0]     pp;
    logic [PROD_W-1:0]   pp_shifted;
    logic [PROD_W-1:0]   acc_sum;

    genvar gi;
    generate
        for (gi = 0; gi < N_LIMBS; gi++) begin : g_limb
            assign a_limb[gi] = a_reg[gi*LIMB_W +: LIMB_W];
            assign b_limb[gi] = b_reg[gi*LIMB_W +: LIMB_W];
        end
    endgenerate

    // j walks the inner loop over b limbs, i the outer loop over a limbs.
    assign i_idx = k_reg[3:2];
    assign j_idx = k_reg[1:0];
    assign a_sel = a_limb[i_idx];
    assign b_sel = b_limb[j_idx];

    limb_mul_16x16 u_limb_mul (
        .x (a_sel),
        .y (b_sel),
        .p (pp)
    );

    assign pp_shifted = {{(PROD_W-PP_W){1'b0}}, pp} << limb_shift(i_idx, j_idx);
    // (2^64-1)^2 < 2^128, so the 128-bit sum never wraps.
    assign acc_sum    = acc_reg + pp_shifted;

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        out_next   = out_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    acc_next   = '0;
                    k_next     = '0;
                    busy_next  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                acc_next = acc_sum;
                k_next   = k_reg + 1'b1;
                if (k_reg == LAST_STEP) begin
                    out_next   = acc_sum;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    k_next     = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            out_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign out  = out_reg;

endmodule

// File: tb/tb_mul_64x64_seq.sv
// Directed and randomized checks for mul_64x64_seq: latency, done pulse, held start,
// mid-operation reset and product correctness.
module tb_mul_64x64_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [63:0]  a, b;
    logic         busy, done;
    logic [127:0] out;

    int           checks = 0;
    int           passes = 0;
    logic [127:0] last_out;

    always #5 clk = ~clk;

    mul_64x64_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .out   (out),
        .done  (done)
    );

    task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
        return {64'b0, x} * {64'b0, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One accepted operation; a/b are scrambled during MUL to show they are ignored.
    task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                          input logic [127:0] expv);
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "/accept"}, {busy, done, out}, {2'b10, last_out});
        for (int e = 1; e <= 16; e++) begin
            a = rnd64(); b = rnd64();
            tick();
            if (e < 16) check({tag, "/run"}, {busy, done, out}, {2'b10, last_out});
            else        check({tag, "/done"}, {busy, done, out}, {2'b01, expv});
        end
        last_out = expv;
        $display("op %s a=%h b=%h out=%h", tag, x, y, out);
    endtask

    initial begin
        logic [63:0]  ha, hb;
        logic [127:0] hexp;

        reset = 1'b0; start = 1'b0; a = '0; b = '0; last_out = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {busy, done, out}, 130'b0);
        reset = 1'b1;
        tick();
        check("idle_after_reset", {busy, done, out}, 130'b0);

        run_op("one", 64'h1, 64'h1, 128'h1);
        tick();
        check("done_one_cycle", {1'b0, done, out}, {2'b00, last_out});
        run_op("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        run_op("msb_x2", 64'h8000_0000_0000_0000, 64'h2, 128'h1_0000_0000_0000_0000);
        run_op("pattern", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               ref_mul(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210));
        run_op("zero", 64'h0, 64'hDEAD_BEEF_0000_0001, 128'h0);

        // Held-high start: one done every 17 edges, product of operands at each accept.
        start = 1'b1;
        for (int op = 0; op < 4; op++) begin
            ha = rnd64(); hb = rnd64(); a = ha; b = hb;
            hexp = ref_mul(ha, hb);
            tick();
            check("held/accept", {busy, done, out}, {2'b10, last_out});
            for (int e = 1; e <= 16; e++) begin
                a = rnd64(); b = rnd64();
                if (e == 16 && op == 3) start = 1'b0;
                tick();
                if (e < 16) check("held/run", {busy, done, out}, {2'b10, last_out});
                else        check("held/done", {busy, done, out}, {2'b01, hexp});
            end
            last_out = hexp;
            $display("op held%0d a=%h b=%h out=%h", op, ha, hb, out);
        end
        tick();
        check("held/stop", {busy, done, out}, {2'b00, last_out});

        // Reset while k=7: everything clears at once and nothing completes afterwards.
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("pre_reset_busy", {busy, done, out}, {2'b10, last_out});
        #2 reset = 1'b0;
        #1 check("midop_reset", {busy, done, out}, 130'b0);
        #1 reset = 1'b1;
        last_out = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("post_reset_quiet", {busy, done, out}, 130'b0);
        end
        $display("op midop_reset out=%h busy=%b done=%b", out, busy, done);
        run_op("after_reset", 64'h3, 64'h5, 128'hF);

        // Random operands with random idle gaps; done must never appear unrequested.
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("rnd/gap", {busy, done, out}, {2'b00, last_out});
            end
            ha = rnd64(); hb = rnd64();
            if (n % 50 == 0) hb = 64'hFFFF_FFFF_FFFF_FFFF;
            run_op($sformatf("rnd%0d", n), ha, hb, ref_mul(ha, hb));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
